openfire_fsl_link: RTL and testbench
====================================

OPENFIRE_FSL_LINK -- requirements
Module: openfire_fsl_link

Interface
REQ-001 Parameter DEPTH, default 16: FIFO depth in words; SHALL be a power of two, minimum 2.
REQ-002 Parameter ADDR_W, default 4: log2(DEPTH); pointer width.
REQ-003 clock  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 fsl_m_data  input  32  write data from the FSL master (CPU fsl_m_data).
REQ-006 fsl_m_control  input  1  control bit accompanying the write data.
REQ-007 fsl_m_write  input  1  write request, one word per asserted cycle.
REQ-008 fsl_m_full  output  1  FIFO full; writer SHALL NOT write when high.
REQ-009 fsl_s_data  output  32  head-of-FIFO data to the FSL slave (CPU fsl_s_data).
REQ-010 fsl_s_control  output  1  control bit of the head word.
REQ-011 fsl_s_exists  output  1  FIFO non-empty; head word valid.
REQ-012 fsl_s_read  input  1  read/pop request, one word per asserted cycle.
REQ-013 fsl_count  output  ADDR_W+1  number of stored words, 0..DEPTH.
REQ-014 fsl_overflow  output  1  sticky: write attempted while full.
REQ-015 fsl_underflow  output  1  sticky: read attempted while empty.

Function
REQ-016 Storage SHALL be DEPTH entries of 33 bits {control, data}, with write pointer wr_ptr and read pointer rd_ptr (ADDR_W bits each) and an occupancy counter of ADDR_W+1 bits.
REQ-017 Accepted write: fsl_m_write=1 and fsl_m_full=0 -> store {fsl_m_control, fsl_m_data} at wr_ptr; wr_ptr increments modulo DEPTH.
REQ-018 Accepted read: fsl_s_read=1 and fsl_s_exists=0 is not a read; fsl_s_read=1 and fsl_s_exists=1 -> rd_ptr increments modulo DEPTH.
REQ-019 fsl_m_full SHALL equal (count == DEPTH); fsl_s_exists SHALL equal (count != 0); both derived from registered count, not from same-cycle requests.
REQ-020 Full and write in the same cycle as an accepted read: the write SHALL be rejected (full evaluated before the read); count goes DEPTH -> DEPTH-1.
REQ-021 Empty and write in the same cycle as a read: the read SHALL be rejected; the word is stored; count goes 0 -> 1.
REQ-022 Accepted read and accepted write in the same cycle: count unchanged, both pointers advance.
REQ-023 First-word fall-through: fsl_s_data/fsl_s_control SHALL present the entry at rd_ptr combinationally from storage; a word written at edge N is visible with fsl_s_exists=1 after edge N (one-cycle write-to-exists latency).
REQ-024 When fsl_s_exists=0, fsl_s_data/fsl_s_control values are don't-care; benches SHALL NOT check them.
REQ-025 Pointer wrap: after DEPTH accepted writes from reset, wr_ptr SHALL return to 0; ordering SHALL be strictly FIFO across wrap.
REQ-026 fsl_overflow SHALL set at the edge following any cycle with fsl_m_write=1 and fsl_m_full=1, and hold until reset.
REQ-027 fsl_underflow SHALL set at the edge following any cycle with fsl_s_read=1 and fsl_s_exists=0, and hold until reset.
REQ-028 Rejected writes/reads SHALL NOT modify storage, pointers, or count.

Reset
REQ-029 reset=1 at an edge SHALL clear wr_ptr, rd_ptr, count, fsl_overflow, fsl_underflow; outputs after that edge: fsl_m_full=0, fsl_s_exists=0, fsl_count=0.
REQ-030 Reset SHALL take priority over concurrent write/read requests; storage contents need not be cleared.
REQ-031 Reset asserted mid-operation (any count) SHALL discard all stored words; first word written after reset SHALL be the first read.

Verification
REQ-032 Reset, write 0x00000001..0x00000003 (control 0,1,0) on 3 cycles -> count=3, exists=1, head=0x00000001/ctl 0; 3 reads return words in order, ctl 0,1,0; count=0, exists=0.
REQ-033 Fill 16 words 0xA0000000+i -> full=1 at count 16; extra write 0xDEADBEEF -> rejected, overflow=1; drain returns 0xA0000000..0xA000000F only.
REQ-034 At count=16, write+read same cycle -> count=15, full=0, head=0xA0000001, write data absent from FIFO.
REQ-035 At count=0, write 0x12345678 + read same cycle -> count=1, underflow=1, next head=0x12345678.
REQ-036 Continuous write+read for 40 cycles after priming 1 word -> count stays 1, pointers wrap twice, output sequence matches input sequence.
REQ-037 With count=7 and overflow=1, assert reset one cycle -> count=0, exists=0, full=0, overflow=0, underflow=0; write 0x55 then read returns 0x55.

Source files
------------

// File: rtl/openfire_fsl_link_if.sv
// openfire_fsl_link_if
// Bundles the FSL write side (master -> link), the FSL read side
// (link -> slave) and the link status signals into one interface.
//   fsl_m_data/fsl_m_control/fsl_m_write : word offered by the FSL master
//   fsl_m_full                           : link cannot accept a word
//   fsl_s_data/fsl_s_control/fsl_s_exists: head word presented to the slave
//   fsl_s_read                           : slave pops the head word
//   fsl_count                            : stored words, 0..DEPTH
//   fsl_overflow/fsl_underflow           : sticky error flags
// Modport "slave" is the link's own view; modport "master" is the view of
// the CPU side that drives the requests and observes the status.
interface openfire_fsl_link_if #(
  parameter int ADDR_W = 4
);
  logic [31:0]     fsl_m_data;
  logic            fsl_m_control;
  logic            fsl_m_write;
  logic            fsl_m_full;
  logic [31:0]     fsl_s_data;
  logic            fsl_s_control;
  logic            fsl_s_exists;
  logic            fsl_s_read;
  logic [ADDR_W:0] fsl_count;
  logic            fsl_overflow;
  logic            fsl_underflow;

  modport slave (
    input  fsl_m_data, fsl_m_control, fsl_m_write, fsl_s_read,
    output fsl_m_full, fsl_s_data, fsl_s_control, fsl_s_exists,
           fsl_count, fsl_overflow, fsl_underflow
  );

  modport master (
    output fsl_m_data, fsl_m_control, fsl_m_write, fsl_s_read,
    input  fsl_m_full, fsl_s_data, fsl_s_control, fsl_s_exists,
           fsl_count, fsl_overflow, fsl_underflow
  );
endinterface

// File: rtl/openfire_fsl_link.sv
// openfire_fsl_link
// Single-clock first-word-fall-through FIFO carrying 33-bit FSL words
// ({control, data}) from an FSL master to an FSL slave.
// Ports:
//   clock : rising-edge clock for all state
//   reset : synchronous, active-high; clears pointers, count and flags
//   fsl   : openfire_fsl_link_if.slave bundle (write side, read side, status)
// Full/exists are registered flags computed from the next count, so they
// always equal (count == DEPTH) / (count != 0) of the registered count and
// never depend on the requests of the current cycle.
module openfire_fsl_link #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  openfire_fsl_link_if.slave   fsl
);

  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   CNT_ZERO  = (ADDR_W + 1)'(0);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PTR_ZERO  = ADDR_W'(0);

  logic [32:0]       mem_q [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q,  count_d;
  logic              full_q,   full_d;
  logic              exists_q, exists_d;
  logic              ovf_q,    ovf_d;
  logic              unf_q,    unf_d;

  logic              wr_accept;
  logic              rd_accept;

  // Accept decisions use only registered flags: a write while full is
  // rejected even if a read frees a slot this cycle, and a read while empty
  // is rejected even if a write fills the FIFO this cycle.
  always_comb begin
    wr_accept = fsl.fsl_m_write & ~full_q;
    rd_accept = fsl.fsl_s_read  & exists_q;
  end

  // Next-state computation for pointers, occupancy, flags and sticky errors.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;

    // Pointers wrap naturally since DEPTH == 2**ADDR_W.
    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (rd_accept) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    if (fsl.fsl_m_write && full_q) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end

    if (fsl.fsl_s_read && !exists_q) begin
      unf_d = 1'b1;
    end else begin
      unf_d = unf_q;
    end

    full_d   = (count_d == DEPTH_CNT);
    exists_d = (count_d != CNT_ZERO);
  end

  // Control state register with synchronous reset taking priority.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= PTR_ZERO;
      rd_ptr_q <= PTR_ZERO;
      count_q  <= CNT_ZERO;
      full_q   <= 1'b0;
      exists_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      exists_q <= exists_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Word storage; contents are not cleared by reset, only the pointers are.
  always_ff @(posedge clock) begin
    if (wr_accept && !reset) begin
      mem_q[wr_ptr_q] <= {fsl.fsl_m_control, fsl.fsl_m_data};
    end
  end

  // Head word falls through combinationally from storage.
  assign fsl.fsl_s_data    = mem_q[rd_ptr_q][31:0];
  assign fsl.fsl_s_control = mem_q[rd_ptr_q][32];

  assign fsl.fsl_m_full    = full_q;
  assign fsl.fsl_s_exists  = exists_q;
  assign fsl.fsl_count     = count_q;
  assign fsl.fsl_overflow  = ovf_q;
  assign fsl.fsl_underflow = unf_q;

endmodule

// File: tb/tb_openfire_fsl_link.sv
// tb_openfire_fsl_link
// Self-checking bench: a queue-based reference model is checked every cycle,
// a vector table covers the basic write/read sequence, hand-written
// sequences cover full/empty/reset corners, and a random phase closes out.
module tb_openfire_fsl_link;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic clock;
  logic reset;

  openfire_fsl_link_if #(.ADDR_W(ADDR_W)) bus ();

  openfire_fsl_link #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock (clock),
    .reset (reset),
    .fsl   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model: an ordered list of words plus two sticky flags.
  logic [32:0] q[$];
  logic        m_ovf;
  logic        m_unf;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of requests, clock it, update the model, compare.
  task automatic step(input logic rst, input logic w, input logic r,
                      input logic [31:0] d, input logic c);
    int sz;
    bit wr_ok;
    bit rd_ok;
    reset             = rst;
    bus.fsl_m_write   = w;
    bus.fsl_s_read    = r;
    bus.fsl_m_data    = d;
    bus.fsl_m_control = c;
    @(posedge clock);
    #1;
    sz = q.size();
    if (rst) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      wr_ok = w && (sz < DEPTH);
      rd_ok = r && (sz > 0);
      if (w && sz == DEPTH) m_ovf = 1'b1;
      if (r && sz == 0)     m_unf = 1'b1;
      if (rd_ok) void'(q.pop_front());
      if (wr_ok) q.push_back({c, d});
    end
    reset           = 1'b0;
    bus.fsl_m_write = 1'b0;
    bus.fsl_s_read  = 1'b0;
    chk("model_count",  64'(bus.fsl_count),     64'(q.size()));
    chk("model_full",   64'(bus.fsl_m_full),    64'(q.size() == DEPTH));
    chk("model_exists", 64'(bus.fsl_s_exists),  64'(q.size() != 0));
    chk("model_ovf",    64'(bus.fsl_overflow),  64'(m_ovf));
    chk("model_unf",    64'(bus.fsl_underflow), 64'(m_unf));
    if (q.size() != 0)
      chk("model_head", 64'({bus.fsl_s_control, bus.fsl_s_data}), 64'(q[0]));
  endtask

  typedef struct {
    logic        w;
    logic        r;
    logic [31:0] d;
    logic        c;
    int          exp_cnt;
    logic        exp_ex;
    logic [32:0] exp_head;
  } vec_t;

  vec_t vecs[6];
  logic [32:0] head;

  initial begin
    reset = 1'b1;
    bus.fsl_m_write = 1'b0;
    bus.fsl_s_read = 1'b0;
    bus.fsl_m_data = 32'h0;
    bus.fsl_m_control = 1'b0;
    m_ovf = 1'b0;
    m_unf = 1'b0;

    // Basic three-word write then three reads.
    vecs[0] = '{1'b1, 1'b0, 32'h00000001, 1'b0, 1, 1'b1, {1'b0, 32'h00000001}};
    vecs[1] = '{1'b1, 1'b0, 32'h00000002, 1'b1, 2, 1'b1, {1'b0, 32'h00000001}};
    vecs[2] = '{1'b1, 1'b0, 32'h00000003, 1'b0, 3, 1'b1, {1'b0, 32'h00000001}};
    vecs[3] = '{1'b0, 1'b1, 32'h00000000, 1'b0, 2, 1'b1, {1'b1, 32'h00000002}};
    vecs[4] = '{1'b0, 1'b1, 32'h00000000, 1'b0, 1, 1'b1, {1'b0, 32'h00000003}};
    vecs[5] = '{1'b0, 1'b1, 32'h00000000, 1'b0, 0, 1'b0, 33'h0};

    // Reset state.
    step(1'b1, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b1);
    chk("rst_count",  64'(bus.fsl_count),    64'd0);
    chk("rst_full",   64'(bus.fsl_m_full),   64'd0);
    chk("rst_exists", 64'(bus.fsl_s_exists), 64'd0);

    foreach (vecs[i]) begin
      step(1'b0, vecs[i].w, vecs[i].r, vecs[i].d, vecs[i].c);
      chk("vec_count",  64'(bus.fsl_count),    64'(vecs[i].exp_cnt));
      chk("vec_exists", 64'(bus.fsl_s_exists), 64'(vecs[i].exp_ex));
      if (vecs[i].exp_ex)
        chk("vec_head", 64'({bus.fsl_s_control, bus.fsl_s_data}), 64'(vecs[i].exp_head));
    end

    // Fill to full, overflow attempt, write+read while full, drain.
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, 32'hA0000000 + 32'(i), 1'b0);
    chk("fill_full",  64'(bus.fsl_m_full), 64'd1);
    chk("fill_count", 64'(bus.fsl_count),  64'd16);
    step(1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 1'b1);
    chk("ovf_set",   64'(bus.fsl_overflow), 64'd1);
    chk("ovf_count", 64'(bus.fsl_count),    64'd16);
    step(1'b0, 1'b1, 1'b1, 32'hCAFEF00D, 1'b1);
    chk("fullwr_count", 64'(bus.fsl_count),  64'd15);
    chk("fullwr_full",  64'(bus.fsl_m_full), 64'd0);
    chk("fullwr_head",  64'({bus.fsl_s_control, bus.fsl_s_data}), {31'd0, 1'b0, 32'hA0000001});
    for (int i = 1; i < DEPTH; i++) begin
      head = {bus.fsl_s_control, bus.fsl_s_data};
      chk("drain_head", 64'(head), 64'({1'b0, 32'hA0000000 + 32'(i)}));
      step(1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
    end
    chk("drain_empty", 64'(bus.fsl_s_exists), 64'd0);

    // Write and read together while empty: read rejected, word kept.
    step(1'b0, 1'b1, 1'b1, 32'h12345678, 1'b0);
    chk("empwr_count", 64'(bus.fsl_count),     64'd1);
    chk("empwr_unf",   64'(bus.fsl_underflow), 64'd1);
    chk("empwr_head",  64'(bus.fsl_s_data),    64'h12345678);

    // Streaming through one primed word, wrapping pointers twice.
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'h00001000, 1'b0);
    for (int i = 1; i <= 40; i++) begin
      chk("stream_head", 64'(bus.fsl_s_data), 64'(32'h00001000 + 32'(i - 1)));
      step(1'b0, 1'b1, 1'b1, 32'h00001000 + 32'(i), i[0]);
      chk("stream_count", 64'(bus.fsl_count), 64'd1);
    end

    // Reset mid-operation with count=7 and overflow set.
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 1'b1, 1'b0, 32'(i), 1'b0);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
    chk("pre_rst_count", 64'(bus.fsl_count),    64'd7);
    chk("pre_rst_ovf",   64'(bus.fsl_overflow), 64'd1);
    step(1'b1, 1'b1, 1'b1, 32'h77777777, 1'b0);
    chk("mid_rst_count", 64'(bus.fsl_count),     64'd0);
    chk("mid_rst_ex",    64'(bus.fsl_s_exists),  64'd0);
    chk("mid_rst_full",  64'(bus.fsl_m_full),    64'd0);
    chk("mid_rst_ovf",   64'(bus.fsl_overflow),  64'd0);
    chk("mid_rst_unf",   64'(bus.fsl_underflow), 64'd0);
    step(1'b0, 1'b1, 1'b0, 32'h00000055, 1'b0);
    chk("post_rst_head", 64'(bus.fsl_s_data), 64'h55);
    step(1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
    chk("post_rst_empty", 64'(bus.fsl_s_exists), 64'd0);

    // Random traffic with alternating bias so both full and empty occur.
    for (int k = 0; k < 1200; k++) begin
      int wb;
      wb = ((k / 150) % 2 == 1) ? 80 : 25;
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 99) < wb),
           ($urandom_range(0, 99) < 50),
           $urandom(), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
